qdr_user_port: RTL
==================

// Module: qdr_user_port
// PURPOSE
//  Client-side master for the QDRII+ controller user interface. Sits between fabric logic and the controller.
//  Accepts independent write and read requests (valid/ready), drives the app_wr*/app_rd* command ports and
//  returns read data with the requester's tag by matching in-order app_rd_valid0 beats to a tag FIFO.
// PARAMETERS
//  ADDR_WIDTH  18  memory word address width (app_*_addr0)
//  DATA_WIDTH  36  memory data width; BW_WIDTH = DATA_WIDTH/9
//  BURST_LEN   4   beats per access; APP_DW = BURST_LEN*DATA_WIDTH, APP_BW = BURST_LEN*BW_WIDTH
//  TAG_WIDTH   4   read request tag width
//  TAG_AW      4   log2 of tag FIFO depth (max outstanding reads = 2**TAG_AW)
// PORTS
//  sys_clk        in   1           controller user clock; all logic in this domain
//  sys_rst        in   1           synchronous, active-high reset
//  cal_done       in   1           controller calibration complete
//  wr_valid       in   1           write request valid
//  wr_ready       out  1           write request accepted when valid&ready
//  wr_addr        in   ADDR_WIDTH  write address
//  wr_data        in   APP_DW      write burst data
//  wr_be          in   APP_BW      byte enables, active high
//  rd_valid       in   1           read request valid
//  rd_ready       out  1           read request accepted when valid&ready
//  rd_addr        in   ADDR_WIDTH  read address
//  rd_tag         in   TAG_WIDTH   tag returned with the read data
//  rsp_valid      out  1           read response valid, single-cycle pulse, no backpressure
//  rsp_data       out  APP_DW      read burst data
//  rsp_tag        out  TAG_WIDTH   tag of the request being answered
//  rd_outstanding out  TAG_AW+1    reads issued, not yet returned
//  err_unexpected out  1           sticky: app_rd_valid0 with no outstanding read
//  app_wr_cmd0    out  1           controller write command strobe
//  app_wr_addr0   out  ADDR_WIDTH
//  app_wr_data0   out  APP_DW
//  app_wr_bw_n0   out  APP_BW      byte-write enables, active low (= ~wr_be)
//  app_rd_cmd0    out  1           controller read command strobe
//  app_rd_addr0   out  ADDR_WIDTH
//  app_rd_valid0  in   1           read data valid from controller
//  app_rd_data0   in   APP_DW      read data from controller
// BEHAVIOUR
//  - Reset: all outputs 0 except app_wr_bw_n0 all ones; FSM=WAIT_CAL; tag FIFO empty; err cleared.
//  - FSM: WAIT_CAL -> RUN when cal_done=1; RUN -> WAIT_CAL when cal_done=0. Outstanding reads stay tracked.
//  - wr_ready = (state==RUN). rd_ready = (state==RUN) && !fifo_full. A pop in the same cycle does not
//    unblock a full FIFO. This is registered-free and combinational from state/full only.
//  - Write accept in cycle N: app_wr_cmd0=1 for exactly one cycle in N+1. Addr/data/bw_n are registered.
//    Back-to-back accepts give back-to-back strobes.
//  - Read accept in cycle N: push rd_tag; app_rd_cmd0=1 in cycle N+1 with app_rd_addr0.
//    Write and read may be accepted in the same cycle; both strobes are issued in N+1.
//  - app_*_addr0/data0 hold their last value when the strobe is low.
//  - app_rd_valid0 in cycle M with FIFO non-empty: pop. rsp_valid=1 in M+1 with app_rd_data0 (registered)
//    and the popped tag. Responses stay in request order.
//  - app_rd_valid0 with FIFO empty: data dropped, rsp_valid stays 0, err_unexpected=1 until sys_rst.
//  - Push and pop in the same cycle: rd_outstanding unchanged. The counter is never over/underflowed;
//    pointers wrap modulo 2**TAG_AW.
//  - sys_rst mid-operation: in-flight strobes are dropped and the FIFO is flushed.
//    The controller is reset alongside this block.
// STRUCTURE
//  - qdr_user_pkg: APP_DW/APP_BW derivation functions; FSM state encoding (WAIT_CAL=0, RUN=1).
//  - Sub-module qdr_tag_fifo: synchronous FIFO, width TAG_WIDTH, depth 2**TAG_AW, with full/empty/count.
//  - Top level contains the FSM, command registers and response register.
// TESTING
//  - cal_done=0, wr_valid=1 -> wr_ready=0, no app_wr_cmd0. Raise cal_done -> accept the next cycle,
//    strobe one cycle later.
//  - Write addr 0x00123, wr_be=16'h00FF -> app_wr_cmd0 pulse with app_wr_addr0=0x00123 and
//    app_wr_bw_n0=16'hFF00.
//  - 3 reads, tags 5, 9, 2; controller model returns data after 12 cycles ->
//    rsp_tag sequence 5, 9, 2 with matching data; rd_outstanding 3->0.
//  - TAG_AW=2: 4 reads with no returns -> rd_ready=0 with rd_outstanding=4.
//    Return one -> rd_ready=1 the next cycle.
//  - app_rd_valid0 pulse while FIFO empty -> rsp_valid stays 0, err_unexpected=1 until sys_rst.
//  - Same-cycle write+read accept, plus push/pop in one cycle -> both strobes issued in N+1;
//    rd_outstanding unchanged.

Source files
------------

// File: rtl/qdr_user_pkg.sv
// Shared types and width helpers for the QDRII+ user-port master.
//   state_e : command FSM encoding (StWaitCal = 0, StRun = 1)
//   app_dw  : controller burst data width  = burst_len * data_width
//   app_bw  : controller burst byte-write width = burst_len * (data_width / 9)
package qdr_user_pkg;

  typedef enum logic {
    StWaitCal = 1'b0,
    StRun     = 1'b1
  } state_e;

  function automatic int unsigned app_dw(input int unsigned burst_len,
                                         input int unsigned data_width);
    return burst_len * data_width;
  endfunction

  // One byte-write lane per 9-bit QDR byte.
  function automatic int unsigned app_bw(input int unsigned burst_len,
                                         input int unsigned data_width);
    return burst_len * (data_width / 9);
  endfunction

endpackage

// File: rtl/qdr_tag_fifo.sv
// Synchronous tag FIFO holding the tags of issued, not yet answered reads.
//   clk, rst          : clock, synchronous active-high reset (flushes contents)
//   push, push_data   : write a tag (ignored when full)
//   pop, pop_data     : drop the head tag (ignored when empty); pop_data shows the head
//   full, empty, count: occupancy status, count ranges 0..Depth
module qdr_tag_fifo #(
  parameter int unsigned Width     = 4,
  parameter int unsigned AddrWidth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [Width-1:0]     push_data,
  input  logic                 pop,
  output logic [Width-1:0]     pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [AddrWidth:0]   count
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [Width-1:0]     mem_q [Depth];
  logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrWidth:0]   count_q;
  logic                 do_push, do_pop;

  assign full     = (count_q == (AddrWidth + 1)'(Depth));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointers wrap naturally at Depth; the counter can never leave 0..Depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/qdr_user_port.sv
// Client-side master for the QDRII+ controller user interface.
//   sys_clk/sys_rst/cal_done : clock, sync active-high reset, calibration complete
//   wr_*                     : write request (valid/ready, addr, burst data, active-high byte enables)
//   rd_*                     : read request (valid/ready, addr, tag)
//   rsp_*                    : read response pulse with data and the requester's tag
//   rd_outstanding           : reads issued and not yet returned
//   err_unexpected           : sticky flag, read data arrived with nothing outstanding
//   app_*                    : controller command/data ports (registered strobes, one cycle after accept)
module qdr_user_port
  import qdr_user_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = 18,
  parameter  int unsigned DATA_WIDTH = 36,
  parameter  int unsigned BURST_LEN  = 4,
  parameter  int unsigned TAG_WIDTH  = 4,
  parameter  int unsigned TAG_AW     = 4,
  localparam int unsigned APP_DW     = app_dw(BURST_LEN, DATA_WIDTH),
  localparam int unsigned APP_BW     = app_bw(BURST_LEN, DATA_WIDTH)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cal_done,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [APP_DW-1:0]     wr_data,
  input  logic [APP_BW-1:0]     wr_be,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [TAG_WIDTH-1:0]  rd_tag,
  output logic                  rsp_valid,
  output logic [APP_DW-1:0]     rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic [TAG_AW:0]       rd_outstanding,
  output logic                  err_unexpected,
  output logic                  app_wr_cmd0,
  output logic [ADDR_WIDTH-1:0] app_wr_addr0,
  output logic [APP_DW-1:0]     app_wr_data0,
  output logic [APP_BW-1:0]     app_wr_bw_n0,
  output logic                  app_rd_cmd0,
  output logic [ADDR_WIDTH-1:0] app_rd_addr0,
  input  logic                  app_rd_valid0,
  input  logic [APP_DW-1:0]     app_rd_data0
);

  state_e state_q, state_d;

  logic                  wr_accept, rd_accept;
  logic                  fifo_full, fifo_empty;
  logic [TAG_WIDTH-1:0]  fifo_head;
  logic                  rsp_fire;

  logic                  wr_cmd_q, rd_cmd_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic [APP_DW-1:0]     wr_data_q;
  logic [APP_BW-1:0]     wr_bw_n_q;
  logic                  rsp_valid_q;
  logic [APP_DW-1:0]     rsp_data_q;
  logic [TAG_WIDTH-1:0]  rsp_tag_q;
  logic                  err_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= StWaitCal;
    else         state_q <= state_d;
  end

  // Ready depends only on state and FIFO fullness, so a same-cycle pop never frees a slot.
  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    unique case (state_q)
      StWaitCal: begin
        if (cal_done) state_d = StRun;
      end
      StRun: begin
        wr_ready = 1'b1;
        rd_ready = !fifo_full;
        if (!cal_done) state_d = StWaitCal;
      end
    endcase
  end

  assign wr_accept = wr_valid && wr_ready;
  assign rd_accept = rd_valid && rd_ready;
  assign rsp_fire  = app_rd_valid0 && !fifo_empty;

  qdr_tag_fifo #(
    .Width     (TAG_WIDTH),
    .AddrWidth (TAG_AW)
  ) u_tag_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (rd_accept),
    .push_data (rd_tag),
    .pop       (app_rd_valid0),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rd_outstanding)
  );

  // Command registers: strobes last one cycle, address/data hold between strobes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_cmd_q  <= 1'b0;
      rd_cmd_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_bw_n_q <= '1;
      rd_addr_q <= '0;
    end else begin
      wr_cmd_q <= wr_accept;
      rd_cmd_q <= rd_accept;
      if (wr_accept) begin
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
        wr_bw_n_q <= ~wr_be;
      end
      if (rd_accept) rd_addr_q <= rd_addr;
    end
  end

  // Response register; returns with nothing outstanding are dropped and flagged.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_data_q <= app_rd_data0;
        rsp_tag_q  <= fifo_head;
      end
      if (app_rd_valid0 && fifo_empty) err_q <= 1'b1;
    end
  end

  assign app_wr_cmd0    = wr_cmd_q;
  assign app_wr_addr0   = wr_addr_q;
  assign app_wr_data0   = wr_data_q;
  assign app_wr_bw_n0   = wr_bw_n_q;
  assign app_rd_cmd0    = rd_cmd_q;
  assign app_rd_addr0   = rd_addr_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_tag        = rsp_tag_q;
  assign err_unexpected = err_q;

endmodule
